// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared geometry, respawn, colour and direction definitions for the pong playfield
package pong_pkg;

    // Default playfield geometry in pixels.
    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_BORDER    = 8;
    localparam int DEF_BALL_SIZE = 16;
    localparam int DEF_PADDLE_W  = 128;
    localparam int DEF_PADDLE_H  = 8;
    localparam int DEF_PADDLE_Y  = 440;

    // Ball spawn point (also the reset position) and paddle reset position.
    localparam logic [9:0] RESPAWN_X      = 10'd312;
    localparam logic [8:0] RESPAWN_Y      = 9'd232;
    localparam logic [9:0] PADDLE_RESET_X = 10'd256;

    // One-bit direction: POS moves +1 per frame, NEG moves -1 per frame.
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam rgb_t RGB_OFF    = 3'b000;
    localparam rgb_t RGB_BALL   = 3'b110;
    localparam rgb_t RGB_BORDER = 3'b111;
    localparam rgb_t RGB_PADDLE = 3'b010;

endpackage

// File: rtl/pong_ball_motion.sv
// rtl/pong_ball_motion.sv - ball hit probes, direction/position update and respawn
//
// Ports:
//   clk, rst_n      pixel clock, synchronous active-low reset
//   px, py          zero-extended raster position (11 bits)
//   active          raster position is inside the visible area
//   obstacle        border or paddle covers the current pixel
//   frame_tick      once-per-frame update strobe (outside the visible area)
//   ball_x, ball_y  current ball top-left corner
//   in_ball         current pixel lies on the ball
//   miss            combinational: this frame_tick moves the ball out of the bottom
module pong_ball_motion
    import pong_pkg::*;
#(
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int BALL_SIZE = DEF_BALL_SIZE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] px,
    input  logic [10:0] py,
    input  logic        active,
    input  logic        obstacle,
    input  logic        frame_tick,
    output logic [9:0]  ball_x,
    output logic [8:0]  ball_y,
    output logic        in_ball,
    output logic        miss
);

    localparam logic [10:0]        SIZE_W     = 11'(BALL_SIZE);
    localparam logic [10:0]        MID_W      = 11'(BALL_SIZE / 2);
    localparam logic [10:0]        LAST_W     = 11'(BALL_SIZE - 1);
    localparam logic signed [10:0] MISS_LIMIT = 11'(V_ACTIVE - BALL_SIZE);

    logic [9:0]         ball_x_q, ball_x_d;
    logic [8:0]         ball_y_q, ball_y_d;
    dir_e               dx_q, dx_d, dy_q, dy_d;
    dir_e               dx_n, dy_n;
    logic               left_q, left_d, right_q, right_d;
    logic               top_q, top_d, bot_q, bot_d;
    logic [10:0]        bx_w, by_w, lx, ly;
    logic               probe_hit;
    logic [9:0]         next_x;
    logic signed [10:0] next_y;

    always_comb begin
        bx_w      = {1'b0, ball_x_q};
        by_w      = {2'b0, ball_y_q};
        lx        = px - bx_w;
        ly        = py - by_w;
        in_ball   = active && (px >= bx_w) && (px < bx_w + SIZE_W)
                           && (py >= by_w) && (py < by_w + SIZE_W);
        probe_hit = in_ball && obstacle;

        // Opposite probes both hit (e.g. wedged in a corner) leave the direction alone.
        dx_n = dx_q;
        if (left_q && !right_q)      dx_n = DIR_POS;
        else if (right_q && !left_q) dx_n = DIR_NEG;
        dy_n = dy_q;
        if (top_q && !bot_q)         dy_n = DIR_POS;
        else if (bot_q && !top_q)    dy_n = DIR_NEG;

        next_x = (dx_n == DIR_NEG) ? ball_x_q - 10'd1 : ball_x_q + 10'd1;
        next_y = (dy_n == DIR_NEG) ? $signed(by_w) - 11'sd1 : $signed(by_w) + 11'sd1;
        miss   = frame_tick && (next_y > MISS_LIMIT);

        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        left_d   = left_q  | (probe_hit && lx == 11'd0  && ly == MID_W);
        right_d  = right_q | (probe_hit && lx == LAST_W && ly == MID_W);
        top_d    = top_q   | (probe_hit && lx == MID_W  && ly == 11'd0);
        bot_d    = bot_q   | (probe_hit && lx == MID_W  && ly == LAST_W);

        if (frame_tick) begin
            left_d  = 1'b0;
            right_d = 1'b0;
            top_d   = 1'b0;
            bot_d   = 1'b0;
            if (miss) begin
                ball_x_d = RESPAWN_X;
                ball_y_d = RESPAWN_Y;
                dx_d     = DIR_POS;
                dy_d     = DIR_NEG;
            end else begin
                ball_x_d = next_x;
                ball_y_d = next_y[8:0];
                dx_d     = dx_n;
                dy_d     = dy_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ball_x_q <= RESPAWN_X;
            ball_y_q <= RESPAWN_Y;
            dx_q     <= DIR_POS;
            dy_q     <= DIR_NEG;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            top_q    <= 1'b0;
            bot_q    <= 1'b0;
        end else begin
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            left_q   <= left_d;
            right_q  <= right_d;
            top_q    <= top_d;
            bot_q    <= bot_d;
        end
    end

    assign ball_x = ball_x_q;
    assign ball_y = ball_y_q;

endmodule

// File: rtl/pong_playfield.sv
// rtl/pong_playfield.sv - pong playfield renderer: border/paddle decode, colour mux, miss pulse, score
//
// Ports:
//   clk, rst_n            pixel clock, synchronous active-low reset
//   pix_x, pix_y          raster position from the sync generator
//   paddle_pos            requested paddle left edge, clamped and latched once per frame
//   vga_r, vga_g, vga_b   registered pixel colour, one cycle behind pix_x/pix_y
//   miss_pulse            one-cycle pulse after the frame update that lost the ball
//   score                 miss counter when PONG_SCORE_EN is defined, otherwise 0
module pong_playfield
    import pong_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int BORDER    = DEF_BORDER,
    parameter int BALL_SIZE = DEF_BALL_SIZE,
    parameter int PADDLE_W  = DEF_PADDLE_W,
    parameter int PADDLE_H  = DEF_PADDLE_H,
    parameter int PADDLE_Y  = DEF_PADDLE_Y
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pix_x,
    input  logic [8:0] pix_y,
    input  logic [9:0] paddle_pos,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b,
    output logic       miss_pulse,
    output logic [7:0] score
);

    localparam logic [10:0] H_ACT_W   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W   = 11'(V_ACTIVE);
    localparam logic [10:0] BORDER_W  = 11'(BORDER);
    localparam logic [10:0] RIGHT_W   = 11'(H_ACTIVE - BORDER);
    localparam logic [10:0] PAD_TOP_W = 11'(PADDLE_Y);
    localparam logic [10:0] PAD_BOT_W = 11'(PADDLE_Y + PADDLE_H - 1);
    localparam logic [10:0] PAD_SPAN  = 11'(PADDLE_W - 1);
    localparam logic [9:0]  PAD_MIN   = 10'(BORDER);
    localparam logic [9:0]  PAD_MAX   = 10'(H_ACTIVE - BORDER - PADDLE_W);

    logic [10:0] px, py, pad_w;
    logic        active, border, paddle, frame_tick;
    logic [9:0]  paddle_x_q, paddle_x_d;
    rgb_t        rgb_q, rgb_d;
    logic        miss_pulse_q, miss_pulse_d;
    logic [9:0]  ball_x;
    logic [8:0]  ball_y;
    logic        in_ball, ball_miss;

    always_comb begin
        px         = {1'b0, pix_x};
        py         = {2'b0, pix_y};
        pad_w      = {1'b0, paddle_x_q};
        active     = (px < H_ACT_W) && (py < V_ACT_W);
        border     = active && ((px < BORDER_W) || (px >= RIGHT_W) || (py < BORDER_W));
        paddle     = active && (px >= pad_w) && (px <= pad_w + PAD_SPAN)
                            && (py >= PAD_TOP_W) && (py <= PAD_BOT_W);
        frame_tick = (px == 11'd0) && (py == V_ACT_W);

        paddle_x_d = paddle_x_q;
        if (frame_tick) begin
            if (paddle_pos < PAD_MIN)      paddle_x_d = PAD_MIN;
            else if (paddle_pos > PAD_MAX) paddle_x_d = PAD_MAX;
            else                           paddle_x_d = paddle_pos;
        end

        rgb_d = RGB_OFF;
        if (in_ball)     rgb_d = RGB_BALL;
        else if (border) rgb_d = RGB_BORDER;
        else if (paddle) rgb_d = RGB_PADDLE;

        miss_pulse_d = ball_miss;
    end

    pong_ball_motion #(
        .V_ACTIVE  (V_ACTIVE),
        .BALL_SIZE (BALL_SIZE)
    ) u_motion (
        .clk        (clk),
        .rst_n      (rst_n),
        .px         (px),
        .py         (py),
        .active     (active),
        .obstacle   (border | paddle),
        .frame_tick (frame_tick),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .in_ball    (in_ball),
        .miss       (ball_miss)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            paddle_x_q   <= PADDLE_RESET_X;
            rgb_q        <= RGB_OFF;
            miss_pulse_q <= 1'b0;
        end else begin
            paddle_x_q   <= paddle_x_d;
            rgb_q        <= rgb_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    assign vga_r      = rgb_q.r;
    assign vga_g      = rgb_q.g;
    assign vga_b      = rgb_q.b;
    assign miss_pulse = miss_pulse_q;

`ifdef PONG_SCORE_EN
    logic [7:0] score_q, score_d;

    // Counts on the same edge that raises miss_pulse; wraps naturally at 8 bits.
    always_comb score_d = score_q + {7'd0, ball_miss};

    always_ff @(posedge clk) begin
        if (!rst_n) score_q <= 8'd0;
        else        score_q <= score_d;
    end

    assign score = score_q;
`else
    assign score = 8'd0;
`endif

endmodule
